alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end for one shared ALU.
// Two requesters, one operation in flight at a time.
module alu_arbiter #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_out,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  input  logic         rsp_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       last_grant;
  logic       own_id;
  logic       pick0;
  logic       pick1;
  logic       err;
  logic [W:0] sum;

  // On contention the requester not served last wins.
  always_comb begin
    pick0 = req0_valid & (~req1_valid | last_grant);
    pick1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign req0_ready = ~reset & (state == IDLE) & pick0;
  assign req1_ready = ~reset & (state == IDLE) & pick1;

  // Error flag from the latched operands, one bit wider.
  always_comb begin
    sum = {1'b0, alu_x} + {1'b0, alu_y};
    err = 1'b0;
    unique case (alu_op)
      3'b000:  err = sum[W];
      3'b001:  err = alu_x < alu_y;
      3'b010:  err = alu_x[W-1];
      default: err = 1'b0;
    endcase
  end

  // Control FSM; operand regs double as the ALU drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      own_id     <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_op     <= 3'b000;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            pick0: begin
              alu_x      <= req0_x;
              alu_y      <= req0_y;
              alu_op     <= req0_op;
              own_id     <= 1'b0;
              last_grant <= 1'b0;
              busy       <= 1'b1;
              state      <= EXEC;
            end
            pick1: begin
              alu_x      <= req1_x;
              alu_y      <= req1_y;
              alu_op     <= req1_op;
              own_id     <= 1'b1;
              last_grant <= 1'b1;
              busy       <= 1'b1;
              state      <= EXEC;
            end
            default: begin
              busy <= 1'b0;
            end
          endcase
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= own_id;
          rsp_data  <= alu_out;
          rsp_err   <= err;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level model.
module tb_alu_arbiter;

  localparam int W    = 17;
  localparam int M    = 1 << W;
  localparam int MASK = M - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [W-1:0] alu_x, alu_y, alu_out;
  logic [2:0]   alu_op;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         rsp_ready;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Shared combinational ALU seen by the arbiter.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      3'b000: alu_out = alu_x + alu_y;
      3'b001: alu_out = alu_x - alu_y;
      3'b010: alu_out = alu_x << 1;
      3'b011: alu_out = alu_x >> 1;
      3'b100: alu_out = alu_x & alu_y;
      3'b101: alu_out = alu_x | alu_y;
      3'b110: alu_out = alu_x ^ alu_y;
      default: alu_out = ~alu_x;
    endcase
  end

  typedef struct {
    bit         id;
    logic [2:0] op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] d;
    bit         e;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // Expected result in integer arithmetic.
  function automatic void ref_op(input int op,
                                 input int x,
                                 input int y,
                                 output int d,
                                 output int e);
    d = 0;
    e = 0;
    case (op)
      0: begin d = (x + y) % M; e = int'(x + y >= M); end
      1: begin d = (x - y + M) % M; e = int'(x < y); end
      2: begin d = (x * 2) % M; e = int'(x >= M / 2); end
      3: d = x / 2;
      4: d = x & y;
      5: d = x | y;
      6: d = x ^ y;
      default: d = MASK - x;
    endcase
  endfunction

  task automatic chk_reset_outs(input string t);
    chk({t, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({t, "_rsp_id"}, 32'(rsp_id), 0);
    chk({t, "_rsp_data"}, 32'(rsp_data), 0);
    chk({t, "_rsp_err"}, 32'(rsp_err), 0);
    chk({t, "_ready0"}, 32'(req0_ready), 0);
    chk({t, "_ready1"}, 32'(req1_ready), 0);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_alu_x"}, 32'(alu_x), 0);
    chk({t, "_alu_y"}, 32'(alu_y), 0);
    chk({t, "_alu_op"}, 32'(alu_op), 0);
  endtask

  task automatic drive(input bit id, input logic [2:0] op,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y);
    if (id) begin
      req1_valid = 1'b1;
      req1_op = op; req1_x = x; req1_y = y;
    end else begin
      req0_valid = 1'b1;
      req0_op = op; req0_x = x; req0_y = y;
    end
  endtask

  // Reset held with both requesters valid: reset must win.
  task automatic do_reset(input string t);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outs(t);
    @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    string t;
    t = $sformatf("vec%0d", n);
    @(negedge clk);
    rsp_ready = 1'b1;
    drive(v.id, v.op, v.x, v.y);
    #1;
    chk({t, "_grant"}, {30'd0, req1_ready, req0_ready},
        v.id ? 32'd2 : 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({t, "_exec_busy"}, 32'(busy), 1);
    chk({t, "_exec_rv"}, 32'(rsp_valid), 0);
    @(negedge clk);
    #1;
    chk({t, "_rv"}, 32'(rsp_valid), 1);
    chk({t, "_id"}, 32'(rsp_id), 32'(v.id));
    chk({t, "_data"}, 32'(rsp_data), 32'(v.d));
    chk({t, "_err"}, 32'(rsp_err), 32'(v.e));
    @(negedge clk);
    #1;
    chk({t, "_idle"}, {30'd0, busy, rsp_valid}, 0);
    chk({t, "_alu_hold"}, 32'(alu_x), 32'(v.x));
  endtask

  vec_t vecs[12];

  // Transaction-level model state for the random run.
  bit pv[2];
  int pop[2], px[2], py[2];
  int lastg, g, wait_c, edata, eerr, eid;
  bit inflight;
  int gcyc[$];
  int gid[$];
  logic [W-1:0] held_d;

  initial begin
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0;
    rsp_ready = 0;

    vecs[0]  = '{0, 3'b000, 17'd1, 17'd2, 17'd3, 0};
    vecs[1]  = '{1, 3'b000, 17'h1FFFF, 17'd1, 17'd0, 1};
    vecs[2]  = '{0, 3'b001, 17'd1, 17'd2, 17'h1FFFF, 1};
    vecs[3]  = '{1, 3'b010, 17'h10001, 17'd0, 17'h2, 1};
    vecs[4]  = '{0, 3'b011, 17'd3, 17'd9, 17'd1, 0};
    vecs[5]  = '{1, 3'b100, 17'h0F0F0, 17'h0FF00,
                 17'h0F000, 0};
    vecs[6]  = '{0, 3'b101, 17'h10001, 17'h00100,
                 17'h10101, 0};
    vecs[7]  = '{1, 3'b110, 17'h1FFFF, 17'h0FFFF,
                 17'h10000, 0};
    vecs[8]  = '{0, 3'b111, 17'd0, 17'd5, 17'h1FFFF, 0};
    vecs[9]  = '{1, 3'b001, 17'd5, 17'd5, 17'd0, 0};
    vecs[10] = '{0, 3'b000, 17'h0FFFF, 17'h10000,
                 17'h1FFFF, 0};
    vecs[11] = '{1, 3'b010, 17'h0FFFF, 17'd0,
                 17'h1FFFE, 0};

    do_reset("rst0");
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Contention after reset: grants 0,1,0,1 three apart.
    do_reset("rst1");
    @(negedge clk);
    rsp_ready = 1'b1;
    drive(0, 3'b000, 17'd1, 17'd1);
    drive(1, 3'b000, 17'd2, 17'd2);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req0_ready && req1_ready)
        chk("double_grant", 1, 0);
      if (req0_ready) begin
        gcyc.push_back(c); gid.push_back(0);
      end
      if (req1_ready) begin
        gcyc.push_back(c); gid.push_back(1);
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("cont_count", 32'(gid.size()), 4);
    for (int i = 0; i < 4 && i < gid.size(); i++) begin
      chk($sformatf("cont_id%0d", i), 32'(gid[i]),
          32'(i % 2));
      chk($sformatf("cont_cyc%0d", i), 32'(gcyc[i]),
          32'(3 * i));
    end

    // Backpressure: RESP held five cycles.
    do_reset("rst2");
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(0, 3'b110, 17'h1F0F0, 17'h0FF00);
    #1;
    chk("bp_grant0", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 0;
    drive(1, 3'b000, 17'd3, 17'd4);
    #1;
    chk("bp_exec_r1", 32'(req1_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp_rv%0d", i), 32'(rsp_valid), 1);
      chk($sformatf("bp_d%0d", i), 32'(rsp_data),
          32'h10FF0);
      chk($sformatf("bp_id%0d", i), 32'(rsp_id), 0);
      chk($sformatf("bp_r1_%0d", i), 32'(req1_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_rv", 32'(rsp_valid), 1);
    @(negedge clk);
    #1;
    chk("bp_idle_rv", 32'(rsp_valid), 0);
    chk("bp_idle_busy", 32'(busy), 0);
    chk("bp_idle_r1", 32'(req1_ready), 1);
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    #1;
    chk("bp_r1_rv", 32'(rsp_valid), 1);
    chk("bp_r1_id", 32'(rsp_id), 1);
    chk("bp_r1_d", 32'(rsp_data), 7);

    // Reset during EXEC abandons the operation.
    do_reset("rst3");
    @(negedge clk);
    rsp_ready = 1'b1;
    drive(0, 3'b000, 17'd5, 17'd6);
    #1;
    chk("mid_grant", 32'(req0_ready), 1);
    @(negedge clk);
    req0_valid = 0;
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outs("mid");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_norsp%0d", i),
          {30'd0, busy, rsp_valid}, 0);
    end
    run_vec('{1, 3'b000, 17'd5, 17'd6, 17'd11, 0}, 99);

    // Randomized traffic against the transaction model.
    do_reset("rst4");
    lastg = 1;
    inflight = 0;
    wait_c = 0;
    pv[0] = 0; pv[1] = 0;
    eid = 0; edata = 0; eerr = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (pv[i]) begin
          if ($urandom_range(15) == 0) pv[i] = 0;
        end else if ($urandom_range(1) == 1) begin
          pv[i] = 1;
          pop[i] = int'($urandom_range(7));
          px[i] = ($urandom_range(3) == 0) ? MASK :
                  int'($urandom_range(MASK));
          py[i] = ($urandom_range(3) == 0) ? 1 :
                  int'($urandom_range(MASK));
        end
      end
      req0_valid = pv[0];
      req0_op = 3'(pop[0]);
      req0_x = W'(px[0]);
      req0_y = W'(py[0]);
      req1_valid = pv[1];
      req1_op = 3'(pop[1]);
      req1_x = W'(px[1]);
      req1_y = W'(py[1]);
      rsp_ready = ($urandom_range(9) < 7);
      #1;
      if (inflight) begin
        chk("rnd_no_r0", 32'(req0_ready), 0);
        chk("rnd_no_r1", 32'(req1_ready), 0);
        if (wait_c > 0) begin
          chk("rnd_rv_early", 32'(rsp_valid), 0);
          wait_c--;
        end else begin
          chk("rnd_rv", 32'(rsp_valid), 1);
          chk("rnd_id", 32'(rsp_id), 32'(eid));
          chk("rnd_data", 32'(rsp_data), 32'(edata));
          chk("rnd_err", 32'(rsp_err), 32'(eerr));
          if (rsp_ready) inflight = 0;
        end
      end else begin
        g = -1;
        if (pv[0] && pv[1]) g = (lastg == 0) ? 1 : 0;
        else if (pv[0]) g = 0;
        else if (pv[1]) g = 1;
        chk("rnd_r0", 32'(req0_ready), 32'(g == 0));
        chk("rnd_r1", 32'(req1_ready), 32'(g == 1));
        chk("rnd_idle_rv", 32'(rsp_valid), 0);
        if (g >= 0) begin
          ref_op(pop[g], px[g], py[g], edata, eerr);
          eid = g;
          lastg = g;
          pv[g] = 0;
          inflight = 1;
          wait_c = 1;
        end
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    held_d = rsp_data;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
